// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master (CPOL=0, CPHA=0, MSB first) with an internal SCK half-period divider
module spi_master_ctrl #(
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 25
) (
    input  logic                  i_clk50M,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [FRAME_BITS-1:0] i_tx_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_sck,
    output logic                  o_mosi,
    input  logic                  i_miso,
    output logic                  o_ssel
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bit;
    logic [FRAME_BITS-1:0] r_tx_sh;
    logic [FRAME_BITS-1:0] r_rx_sh;
    logic [FRAME_BITS-1:0] r_rx_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sck;
    logic                  r_mosi;
    logic                  r_ssel;
    logic                  w_phase_end;
    logic [FRAME_BITS-1:0] w_tx_next;

    assign w_phase_end = (r_cnt == CW'(CLK_DIV - 1));
    assign w_tx_next   = r_tx_sh << 1;

    // Frame sequencer: every non-idle phase lasts CLK_DIV cycles, so one wrapping counter times them all
    always_ff @(posedge i_clk50M) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_ssel    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= w_phase_end ? '0 : r_cnt + CW'(1);
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (i_start) begin
                        r_tx_sh <= i_tx_data;
                        r_mosi  <= i_tx_data[FRAME_BITS-1];
                        r_ssel  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_sck   <= 1'b0;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_phase_end) begin
                        r_sck   <= 1'b1;
                        r_rx_sh <= FRAME_BITS'({r_rx_sh, i_miso});
                        r_bit   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_phase_end) begin
                        if (r_sck) begin
                            r_sck <= 1'b0;
                            if (r_bit == BW'(FRAME_BITS - 1)) begin
                                r_state <= HOLD;
                            end else begin
                                r_tx_sh <= w_tx_next;
                                r_mosi  <= w_tx_next[FRAME_BITS-1];
                                r_bit   <= r_bit + BW'(1);
                            end
                        end else begin
                            r_sck   <= 1'b1;
                            r_rx_sh <= FRAME_BITS'({r_rx_sh, i_miso});
                        end
                    end
                end
                HOLD: begin
                    if (w_phase_end) begin
                        r_ssel    <= 1'b1;
                        r_rx_data <= r_rx_sh;
                        r_done    <= 1'b1;
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    if (w_phase_end) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rx_data = r_rx_data;
    assign o_sck     = r_sck;
    assign o_mosi    = r_mosi;
    assign o_ssel    = r_ssel;
endmodule
